pc_fetch_sequencer: RTL and testbench

//  Sequences the program counter register and the instruction-memory fetch.

---
 rtl/pc_fetch_sequencer_pkg.sv | 25 ++
 rtl/pc_fetch_sequencer_if.sv | 15 +
 rtl/pc_fetch_sequencer_next_mux.sv | 62 ++++++
 rtl/pc_fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_seq_pkg : shared encodings and vectors for the PC fetch sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_EXT      = 2'b01,
    CAUSE_MISALIGN = 2'b10
  } cause_t;

  localparam logic [31:0] c_reset_vector = 32'h0000_0000;
  localparam logic [31:0] c_trap_vector  = 32'h0000_0080;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_fetch_sequencer_if : instruction-memory request/ack bus           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer_next_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_next_mux : next-PC priority select with target alignment check    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = c_trap_vector
) (
  input  logic [31:0] pc,
  input  logic        trap,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        take_trap,
  output cause_t      cause_code
);

  logic        w_redirect;
  logic [31:0] w_target;

  always_comb begin
    w_redirect = 1'b0;
    w_target   = '0;
    next_pc    = pc + 32'd4;
    take_trap  = 1'b0;
    cause_code = CAUSE_NONE;

    if (jr) begin
      w_redirect = 1'b1;
      w_target   = jr_target;
    end else if (jump) begin
      w_redirect = 1'b1;
      w_target   = jump_target;
    end else if (branch_taken) begin
      w_redirect = 1'b1;
      w_target   = branch_target;
    end

    // An external trap wins even over a misaligned redirect target.
    if (trap) begin
      next_pc    = TRAP_VECTOR;
      take_trap  = 1'b1;
      cause_code = CAUSE_EXT;
    end else if (w_redirect) begin
      if (w_target[1:0] != 2'b00) begin
        next_pc    = TRAP_VECTOR;
        take_trap  = 1'b1;
        cause_code = CAUSE_MISALIGN;
      end else begin
        next_pc = w_target;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_fetch_sequencer : owns the PC, fetches from imem, selects next PC |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = c_reset_vector,
  parameter logic [31:0] TRAP_VECTOR  = c_trap_vector
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        halt,
  input  logic                        trap,
  input  logic                        branch_taken,
  input  logic [31:0]                 branch_target,
  input  logic                        jump,
  input  logic [31:0]                 jump_target,
  input  logic                        jr,
  input  logic [31:0]                 jr_target,
  pc_fetch_sequencer_if.master        imem,
  output logic [31:0]                 instr,
  output logic                        instr_valid,
  output logic [31:0]                 pc,
  output logic [31:0]                 pc_plus4,
  output logic [31:0]                 epc,
  output logic [1:0]                  cause
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_epc;
  cause_t      r_cause;
  logic        r_instr_valid;

  logic        w_instr_valid_next;
  logic        w_instr_load;
  logic        w_pc_update;
  logic        w_imem_req;
  logic [31:0] w_next_pc;
  logic        w_take_trap;
  cause_t      w_cause_code;

  pc_next_mux #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_mux (
    .pc            (r_pc),
    .trap          (trap),
    .jr            (jr),
    .jr_target     (jr_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (w_next_pc),
    .take_trap     (w_take_trap),
    .cause_code    (w_cause_code)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_BOOT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    w_instr_valid_next = r_instr_valid;
    w_instr_load       = 1'b0;
    w_pc_update        = 1'b0;
    w_imem_req         = 1'b0;

    case (r_state)
      ST_BOOT: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_imem_req = 1'b1;
        // Halt is honoured only once the outstanding fetch has completed.
        if (imem.imem_ack) begin
          if (halt) begin
            w_state_next       = ST_HALTED;
            w_instr_valid_next = 1'b0;
          end else begin
            w_state_next       = ST_EXEC;
            w_instr_load       = 1'b1;
            w_instr_valid_next = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          w_instr_valid_next = 1'b0;
          if (halt) begin
            w_state_next = ST_HALTED;
          end else begin
            w_state_next = ST_FETCH;
            w_pc_update  = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        w_instr_valid_next = 1'b0;
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_epc         <= '0;
      r_cause       <= CAUSE_NONE;
    end else begin
      r_instr_valid <= w_instr_valid_next;
      if (w_instr_load) r_instr <= imem.imem_rdata;
      if (w_pc_update) begin
        r_pc <= w_next_pc;
        if (w_take_trap) begin
          r_epc   <= r_pc;
          r_cause <= w_cause_code;
        end
      end
    end
  end

  assign imem.imem_req  = w_imem_req;
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign pc             = r_pc;
  assign pc_plus4       = r_pc + 32'd4;
  assign epc            = r_epc;
  assign cause          = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_fetch_sequencer : scoreboard bench for the PC fetch sequencer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pc_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        halt  = 1'b0;
  logic        trap  = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic [1:0]  cause;

  pc_fetch_sequencer_if imem_bus ();

  pc_fetch_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .halt          (halt),
    .trap          (trap),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .imem          (imem_bus.master),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .epc           (epc),
    .cause         (cause)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge after the ack edge.
  task automatic fetch_cycle(input int waits, input logic [31:0] word);
    logic [31:0] exp_addr;
    check("queue_depth", 32'(exp_q.size()), 32'd1);
    exp_addr = (exp_q.size() != 0) ? exp_q.pop_front() : m_pc;
    check("fetch_req", 32'(imem_bus.imem_req), 32'd1);
    check("fetch_addr", imem_bus.imem_addr, exp_addr);
    check("pc_plus4", pc_plus4, exp_addr + 32'd4);
    for (int i = 0; i < waits; i++) begin
      imem_bus.imem_ack = 1'b0;
      @(negedge clock);
      check("req_hold", 32'(imem_bus.imem_req), 32'd1);
      check("addr_hold", imem_bus.imem_addr, exp_addr);
      check("valid_wait", 32'(instr_valid), 32'd0);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    @(negedge clock);
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_instr", instr, word);
    check("exec_req", 32'(imem_bus.imem_req), 32'd0);
    m_pc = exp_addr;
    // Garbage with ack still high: must be ignored while in EXEC.
    imem_bus.imem_rdata = ~word;
  endtask

  task automatic exec_cycle(input int stall_cycles, input logic h, input logic t,
                            input logic jr_e, input logic [31:0] jrt,
                            input logic j_e, input logic [31:0] jt,
                            input logic b_e, input logic [31:0] bt);
    logic [31:0] npc, tgt, held_instr;
    logic        sel;
    held_instr = instr;
    halt = h; trap = t; jr = jr_e; jr_target = jrt;
    jump = j_e; jump_target = jt; branch_taken = b_e; branch_target = bt;
    stall = 1'b1;
    for (int i = 0; i < stall_cycles; i++) begin
      @(negedge clock);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", pc, m_pc);
      check("stall_instr", instr, held_instr);
      check("stall_req", 32'(imem_bus.imem_req), 32'd0);
    end
    stall = 1'b0;
    if (!h) begin
      npc = m_pc + 32'd4; sel = 1'b0; tgt = '0;
      if (jr_e)     begin sel = 1'b1; tgt = jrt; end
      else if (j_e) begin sel = 1'b1; tgt = jt;  end
      else if (b_e) begin sel = 1'b1; tgt = bt;  end
      if (t) begin
        m_epc = m_pc; m_cause = 2'b01; npc = 32'h80;
      end else if (sel) begin
        if (tgt[1:0] != 2'b00) begin
          m_epc = m_pc; m_cause = 2'b10; npc = 32'h80;
        end else begin
          npc = tgt;
        end
      end
      m_pc = npc;
      exp_q.push_back(npc);
    end
    @(negedge clock);
    halt = 1'b0; trap = 1'b0; jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    check("next_pc", pc, m_pc);
    check("epc", epc, m_epc);
    check("cause", 32'(cause), 32'(m_cause));
    check("valid_clear", 32'(instr_valid), 32'd0);
    check("req_after_exec", 32'(imem_bus.imem_req), h ? 32'd0 : 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00;
    repeat (2) @(negedge clock);
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cause", 32'(cause), 32'd0);

    reset = 1'b0;
    imem_bus.imem_ack = 1'b1;
    @(negedge clock);
    exp_q.push_back(32'h0);

    fetch_cycle(0, 32'hA000_0000); exec_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch_cycle(0, 32'hA000_0004); exec_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch_cycle(0, 32'hA000_0008); exec_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch_cycle(3, 32'hA000_000C); exec_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    fetch_cycle(0, 32'hB000_0010);
    exec_cycle(0, 0, 0, 0, 0, 1, 32'h40, 1, 32'h80);
    check("jump_over_branch", pc, 32'h40);

    fetch_cycle(0, 32'hB000_0040);
    exec_cycle(4, 0, 0, 1, 32'h22, 1, 32'h48, 0, 0);
    check("misalign_pc", pc, 32'h80);
    check("misalign_epc", epc, 32'h40);
    check("misalign_cause", 32'(cause), 32'd2);

    fetch_cycle(0, 32'hB000_0080);
    exec_cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h24);
    fetch_cycle(0, 32'hB000_0024);
    exec_cycle(0, 0, 1, 1, 32'h100, 0, 0, 0, 0);
    check("trap_pc", pc, 32'h80);
    check("trap_epc", epc, 32'h24);
    check("trap_cause", 32'(cause), 32'd1);

    fetch_cycle(0, 32'hB000_0080);
    exec_cycle(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    fetch_cycle(2, 32'hC000_FFFC);
    exec_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);
    check("cause_sticky", 32'(cause), 32'd1);

    fetch_cycle(0, 32'hC000_0000); exec_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch_cycle(0, 32'hC000_0004); exec_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      imem_bus.imem_ack = 1'b1;
      @(negedge clock);
      check("halt_req", 32'(imem_bus.imem_req), 32'd0);
      check("halt_pc", pc, 32'h4);
      check("halt_valid", 32'(instr_valid), 32'd0);
    end

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    imem_bus.imem_ack = 1'b0;
    exp_q.delete();
    m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00;
    check("rst2_pc", pc, 32'h0);
    check("rst2_cause", 32'(cause), 32'd0);
    check("rst2_req", 32'(imem_bus.imem_req), 32'd0);
    @(negedge clock);
    check("refetch_req", 32'(imem_bus.imem_req), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    check("midfetch_rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("midfetch_rst_instr", instr, 32'h0);
    @(negedge clock);
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("late_ack_instr", instr, 32'h0);
    exp_q.push_back(32'h0);
    fetch_cycle(0, 32'hD000_0000); exec_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch_cycle(1, 32'hD000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
